instruction_sequencer: RTL and testbench



---
 rtl/instruction_sequencer.sv | 99 +++++++++
 tb/tb_instruction_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/instruction_sequencer.sv
// Step counter (T0-T3) and instruction register for the 9-bit simple processor,
// with stall, step-timeout fault and retired-instruction bookkeeping.
module instruction_sequencer #(
    parameter int IW = 9,
    parameter int RW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          run,
    input  logic          stall,
    input  logic [IW-1:0] iin,
    input  logic          clear,
    output logic [IW-1:0] ir,
    output logic [1:0]    count,
    output logic          ir_load,
    output logic          busy,
    output logic          done,
    output logic          fault,
    output logic [RW-1:0] retired
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } step_e;

    step_e         step_q, step_d;
    logic [IW-1:0] ir_q, ir_d;
    logic          done_q, done_d;
    logic          fault_q, fault_d;
    logic [RW-1:0] retired_q, retired_d;

    logic accept;
    logic complete;
    logic timeout;

    // clear only ends an instruction once it has left T0; T3 without clear is a timeout.
    assign accept   = (step_q == T0) && run && !stall && !reset;
    assign complete = (step_q != T0) && clear && !stall;
    assign timeout  = (step_q == T3) && !clear && !stall;

    always_comb begin
        step_d    = step_q;
        ir_d      = ir_q;
        done_d    = 1'b0;
        fault_d   = fault_q;
        retired_d = retired_q;

        if (!stall) begin
            unique case (step_q)
                T0: begin
                    if (run) begin
                        step_d = T1;
                        ir_d   = iin;
                    end
                end
                T1:      step_d = clear ? T0 : T2;
                T2:      step_d = clear ? T0 : T3;
                T3:      step_d = T0;
                default: step_d = T0;
            endcase
        end

        if (complete) begin
            done_d    = 1'b1;
            retired_d = retired_q + {{(RW-1){1'b0}}, 1'b1};
        end
        if (timeout) begin
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            step_q    <= T0;
            ir_q      <= '0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            step_q    <= step_d;
            ir_q      <= ir_d;
            done_q    <= done_d;
            fault_q   <= fault_d;
            retired_q <= retired_d;
        end
    end

    assign ir      = ir_q;
    assign count   = step_q;
    assign ir_load = accept;
    assign busy    = (step_q != T0);
    assign done    = done_q;
    assign fault   = fault_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Scoreboard bench for instruction_sequencer: the driver queues hand-computed per-cycle
// expectations, and an independent monitor pops and compares them every cycle.
module tb_instruction_sequencer;

    logic       clock;
    logic       reset;
    logic       run;
    logic       stall;
    logic [8:0] iin;
    logic       clear;
    logic [8:0] ir;
    logic [1:0] count;
    logic       irLoad;
    logic       busy;
    logic       done;
    logic       fault;
    logic [7:0] retired;

    typedef struct packed {
        logic [1:0] cnt;
        logic [8:0] ir;
        logic       ld;
        logic       busy;
        logic       done;
        logic       fault;
        logic [7:0] ret;
    } obs_t;

    obs_t expQ[$];
    int   total;
    int   bad;
    int   cycleNo;

    instruction_sequencer #(.IW(9), .RW(8)) dut (
        .clock   (clock),
        .reset   (reset),
        .run     (run),
        .stall   (stall),
        .iin     (iin),
        .clear   (clear),
        .ir      (ir),
        .count   (count),
        .ir_load (irLoad),
        .busy    (busy),
        .done    (done),
        .fault   (fault),
        .retired (retired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change on the falling edge; the expectation describes what the outputs
    // must show during that same cycle, before the next rising edge.
    task automatic applyStimulus(input logic chk, input logic rst, input logic r,
                                 input logic s, input logic c, input logic [8:0] w,
                                 input logic [1:0] eCnt, input logic [8:0] eIr,
                                 input logic eLd, input logic eDone, input logic eFault,
                                 input logic [7:0] eRet);
        obs_t e;
        @(negedge clock);
        reset = rst;
        run   = r;
        stall = s;
        clear = c;
        iin   = w;
        if (chk) begin
            e.cnt   = eCnt;
            e.ir    = eIr;
            e.ld    = eLd;
            e.busy  = (eCnt != 2'd0);
            e.done  = eDone;
            e.fault = eFault;
            e.ret   = eRet;
            expQ.push_back(e);
        end
    endtask

    task automatic checkOutput(input obs_t e);
        obs_t a;
        a.cnt   = count;
        a.ir    = ir;
        a.ld    = irLoad;
        a.busy  = busy;
        a.done  = done;
        a.fault = fault;
        a.ret   = retired;
        total++;
        if (a !== e) begin
            bad++;
            $display("[TB] FAIL cycle%0d: got cnt=%0d ir=%o ld=%b busy=%b done=%b fault=%b ret=%0d, want cnt=%0d ir=%o ld=%b busy=%b done=%b fault=%b ret=%0d",
                     cycleNo, a.cnt, a.ir, a.ld, a.busy, a.done, a.fault, a.ret,
                     e.cnt, e.ir, e.ld, e.busy, e.done, e.fault, e.ret);
        end
    endtask

    // Monitor: runs independently of the driver and consumes one expectation per cycle.
    initial begin
        cycleNo = 0;
        forever begin
            @(negedge clock);
            #1;
            cycleNo++;
            if (expQ.size() > 0) checkOutput(expQ.pop_front());
        end
    end

    initial begin
        logic [8:0] w;
        logic [8:0] prevW;
        int         waitCycles;
        total = 0;
        bad   = 0;
        reset = 1'b1;
        run   = 1'b0;
        stall = 1'b0;
        clear = 1'b0;
        iin   = '0;

        applyStimulus(0, 1, 0, 0, 0, 9'o0, 2'd0, 9'o0, 0, 0, 0, 8'd0);
        applyStimulus(0, 1, 0, 0, 0, 9'o0, 2'd0, 9'o0, 0, 0, 0, 8'd0);

        // Reset state, and clear in T0 is ignored.
        applyStimulus(1, 0, 0, 0, 1, 9'o0, 2'd0, 9'o0, 0, 0, 0, 8'd0);

        // mvi: clear in T1.
        applyStimulus(1, 0, 1, 0, 0, 9'o120, 2'd0, 9'o000, 1, 0, 0, 8'd0);
        applyStimulus(1, 0, 0, 0, 1, 9'o000, 2'd1, 9'o120, 0, 0, 0, 8'd0);
        applyStimulus(1, 0, 0, 0, 0, 9'o000, 2'd0, 9'o120, 0, 1, 0, 8'd1);
        applyStimulus(1, 0, 0, 0, 0, 9'o000, 2'd0, 9'o120, 0, 0, 0, 8'd1);

        // add: clear only in T3, next run held high in the done cycle.
        applyStimulus(1, 0, 1, 0, 0, 9'o212, 2'd0, 9'o120, 1, 0, 0, 8'd1);
        applyStimulus(1, 0, 0, 0, 0, 9'o000, 2'd1, 9'o212, 0, 0, 0, 8'd1);
        applyStimulus(1, 0, 0, 0, 0, 9'o000, 2'd2, 9'o212, 0, 0, 0, 8'd1);
        applyStimulus(1, 0, 0, 0, 1, 9'o000, 2'd3, 9'o212, 0, 0, 0, 8'd1);
        applyStimulus(1, 0, 1, 0, 0, 9'o120, 2'd0, 9'o212, 1, 1, 0, 8'd2);
        applyStimulus(1, 0, 0, 0, 1, 9'o000, 2'd1, 9'o120, 0, 0, 0, 8'd2);
        applyStimulus(1, 0, 0, 0, 0, 9'o000, 2'd0, 9'o120, 0, 1, 0, 8'd3);
        applyStimulus(1, 0, 0, 0, 0, 9'o000, 2'd0, 9'o120, 0, 0, 0, 8'd3);

        // Stall in T2 for three cycles while clear and run toggle.
        applyStimulus(1, 0, 1, 0, 0, 9'o212, 2'd0, 9'o120, 1, 0, 0, 8'd3);
        applyStimulus(1, 0, 0, 0, 0, 9'o000, 2'd1, 9'o212, 0, 0, 0, 8'd3);
        applyStimulus(1, 0, 0, 1, 1, 9'o000, 2'd2, 9'o212, 0, 0, 0, 8'd3);
        applyStimulus(1, 0, 0, 1, 0, 9'o000, 2'd2, 9'o212, 0, 0, 0, 8'd3);
        applyStimulus(1, 0, 1, 1, 1, 9'o555, 2'd2, 9'o212, 0, 0, 0, 8'd3);
        applyStimulus(1, 0, 0, 0, 0, 9'o000, 2'd2, 9'o212, 0, 0, 0, 8'd3);
        applyStimulus(1, 0, 0, 0, 1, 9'o000, 2'd3, 9'o212, 0, 0, 0, 8'd3);
        applyStimulus(1, 0, 0, 0, 0, 9'o000, 2'd0, 9'o212, 0, 1, 0, 8'd4);
        applyStimulus(1, 0, 0, 0, 0, 9'o000, 2'd0, 9'o212, 0, 0, 0, 8'd4);

        // Reset in the middle of T2 aborts the instruction without a done.
        applyStimulus(1, 0, 1, 0, 0, 9'o123, 2'd0, 9'o212, 1, 0, 0, 8'd4);
        applyStimulus(1, 0, 0, 0, 0, 9'o000, 2'd1, 9'o123, 0, 0, 0, 8'd4);
        applyStimulus(1, 1, 0, 0, 1, 9'o000, 2'd2, 9'o123, 0, 0, 0, 8'd4);
        applyStimulus(1, 0, 0, 0, 0, 9'o000, 2'd0, 9'o000, 0, 0, 0, 8'd0);

        // Timeout: no clear ever, fault sticks, then a normal mv completes.
        applyStimulus(1, 0, 1, 0, 0, 9'o345, 2'd0, 9'o000, 1, 0, 0, 8'd0);
        applyStimulus(1, 0, 0, 0, 0, 9'o000, 2'd1, 9'o345, 0, 0, 0, 8'd0);
        applyStimulus(1, 0, 0, 0, 0, 9'o000, 2'd2, 9'o345, 0, 0, 0, 8'd0);
        applyStimulus(1, 0, 0, 0, 0, 9'o000, 2'd3, 9'o345, 0, 0, 0, 8'd0);
        applyStimulus(1, 0, 0, 0, 0, 9'o000, 2'd0, 9'o345, 0, 0, 1, 8'd0);
        applyStimulus(1, 0, 1, 0, 0, 9'o012, 2'd0, 9'o345, 1, 0, 1, 8'd0);
        applyStimulus(1, 0, 0, 0, 1, 9'o000, 2'd1, 9'o012, 0, 0, 1, 8'd0);
        applyStimulus(1, 0, 0, 0, 0, 9'o000, 2'd0, 9'o012, 0, 1, 1, 8'd1);
        applyStimulus(1, 1, 0, 0, 0, 9'o000, 2'd0, 9'o012, 0, 0, 1, 8'd1);
        applyStimulus(1, 0, 0, 0, 0, 9'o000, 2'd0, 9'o000, 0, 0, 0, 8'd0);

        // 256 back-to-back mv instructions; run held high in T1 must be ignored.
        prevW = 9'o000;
        for (int i = 0; i < 256; i++) begin
            w = 9'((i * 37 + 11) % 512);
            applyStimulus(1, 0, 1, 0, 1, w, 2'd0, prevW, 1, (i > 0), 0, 8'(i));
            applyStimulus(1, 0, 1, 0, 1, ~w, 2'd1, w, 0, 0, 0, 8'(i));
            prevW = w;
        end
        applyStimulus(1, 0, 0, 0, 0, 9'o000, 2'd0, prevW, 0, 1, 0, 8'd0);
        applyStimulus(1, 0, 0, 0, 0, 9'o000, 2'd0, prevW, 0, 0, 0, 8'd0);

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 20) begin
            @(negedge clock);
            waitCycles++;
        end
        @(negedge clock);
        #2;
        if (expQ.size() > 0) begin
            bad++;
            total++;
            $display("[TB] FAIL drain: got %0d pending expectations, want 0", expQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
